updown_count_sequencer: RTL
===========================

// Module: updown_count_sequencer
// PURPOSE
//   Sequencer/arbiter in front of the 2-bit up/down counter datapath (counter takes clk, a direction bit, and an enable).
//   Two requesters (A, B) submit "step N times in direction D" commands over valid/ready.
//   Block round-robins between A and B, drives cnt_dir/cnt_en, and inserts a settle gap on direction change.
//   The gap absorbs the counter's one-cycle direction-register delay.
// PARAMETERS
//   CNT_W      2  width of controlled counter / shadow position
//   STEP_W     4  width of step-count field per command
//   SETTLE_CYC 1  idle cycles (cnt_en=0) inserted after a direction change, >=1
// PORTS
//   clk        in   1       system clock, rising edge
//   reset      in   1       asynchronous, active-low reset
//   a_valid    in   1       requester A command valid
//   a_dir      in   1       A direction: 0=up, 1=down
//   a_steps    in   STEP_W  A step count
//   a_ready    out  1       A command accepted this cycle (valid&&ready)
//   b_valid    in   1       requester B command valid
//   b_dir      in   1       B direction
//   b_steps    in   STEP_W  B step count
//   b_ready    out  1       B command accepted this cycle
//   cnt_en     out  1       counter step enable (one step per high cycle)
//   cnt_dir    out  1       counter direction (drives counter data_in)
//   busy       out  1       command in progress (state != IDLE)
//   done       out  1       1-cycle pulse, command complete
//   grant_id   out  1       owner of current/last command: 0=A, 1=B
//   shadow_pos out  CNT_W   predicted counter value (see CONFIGURATION)
// BEHAVIOUR
// - Reset (reset=0, async):
//   - state=IDLE; cnt_en=0, cnt_dir=0, busy=0, done=0, grant_id=0, shadow_pos=0.
//   - RR pointer = "B last", so A wins the first tie.
// - Reset asserted mid-command aborts it; no done; the request is re-arbitrated after release.
// - FSM: IDLE -> [SETTLE] -> RUN -> DONE -> IDLE.
// - IDLE arbitration:
//   - Winner = the sole valid requester; if both valid, the one not granted last.
//   - x_ready is combinational, high only for the winner, only in IDLE.
//   - Accept on valid&&ready: latch dir/steps; grant_id and RR pointer update.
// - Accepted steps==0: go straight to DONE; no cnt_en; cnt_dir unchanged.
// - Dir == current cnt_dir: RUN next cycle.
// - Dir differs: cnt_dir takes the new value at the accept edge; SETTLE holds cnt_en=0 for SETTLE_CYC cycles, then RUN.
// - RUN: cnt_en=1 for exactly steps consecutive cycles (remaining-count decrements); last step -> DONE.
// - DONE: done=1 for one cycle, busy=1; then IDLE. Earliest next accept is the first IDLE cycle, so done and ready never coincide.
// - Latency with accept at edge k:
//   - Same dir: cnt_en high cycles k+1..k+N; done at k+N+1.
//   - Dir change: every event shifted by SETTLE_CYC.
// - Between commands: cnt_dir holds its last value; cnt_en=0.
// - Requester rules:
//   - Holds valid/dir/steps stable until accepted.
//   - Inputs when not ready are ignored.
//   - Dropping valid before accept is legal; the request is lost and not an error.
// - Max steps 2^STEP_W-1; no saturation or overflow beyond the counter's own wrap.
// CONFIGURATION
// - SHADOW_POS_EN defined:
//   - shadow_pos steps +1 (dir 0) / -1 (dir 1) modulo 2^CNT_W on each cnt_en cycle.
//   - Wraps 3->0 up, 0->3 down (CNT_W=2); matches counter data_out after the enable edge.
// - SHADOW_POS_EN undefined: shadow_pos tied to 0; no tracking logic.
// TESTING
// 1. Reset, then A: dir=0, steps=4
//    -> a_ready 1 cycle; cnt_en=1 for 4 cycles, cnt_dir=0; done at accept+5.
//    -> shadow_pos 1,2,3,0.
// 2. After test 1, A: dir=1, steps=3
//    -> cnt_dir=1 at accept; 1 SETTLE cycle with cnt_en=0; then 3 enables.
//    -> shadow_pos 3,2,1; done at accept+5.
// 3. A and B both valid and held after reset, steps=2 each
//    -> grants A,B,A,B (grant_id 0,1,0,1); a_ready/b_ready never both high.
// 4. B: steps=0 -> b_ready, no cnt_en, done next cycle, busy for 1 cycle.
// 5. reset=0 during RUN of an A steps=8 command
//    -> all outputs reset asynchronously; after release, held A request re-accepted with the full 8 steps.
// 6. A: dir=0, steps=15 from shadow 0 -> 15 enables; final shadow_pos=3 (wraps 3 times).

Source files
------------

// File: rtl/updown_count_sequencer.sv
// Round-robin sequencer for two step-command requesters driving a 2-bit up/down counter.
// Optional SHADOW_POS_EN macro enables tracking of the predicted counter value on shadow_pos.
module updown_count_sequencer #(
  parameter int CNT_W      = 2,
  parameter int STEP_W     = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic              a_dir,
  input  logic [STEP_W-1:0] a_steps,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic              b_dir,
  input  logic [STEP_W-1:0] b_steps,
  output logic              b_ready,
  output logic              cnt_en,
  output logic              cnt_dir,
  output logic              busy,
  output logic              done,
  output logic              grant_id,
  output logic [CNT_W-1:0]  shadow_pos
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              cnt_en_q, cnt_en_d;
  logic              cnt_dir_q, cnt_dir_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              grant_id_q, grant_id_d;
  logic              rr_b_last_q, rr_b_last_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              a_win_s, b_win_s;
  logic              sel_dir_s;
  logic [STEP_W-1:0] sel_steps_s;

  // Arbitration: the sole valid requester wins; on a tie the one not granted last wins.
  always_comb begin
    a_win_s = 1'b0;
    b_win_s = 1'b0;
    if (state_q == IDLE) begin
      if (a_valid && (!b_valid || rr_b_last_q)) begin
        a_win_s = 1'b1;
      end else if (b_valid) begin
        b_win_s = 1'b1;
      end else begin
        a_win_s = 1'b0;
        b_win_s = 1'b0;
      end
    end else begin
      a_win_s = 1'b0;
      b_win_s = 1'b0;
    end
  end

  assign a_ready     = a_win_s;
  assign b_ready     = b_win_s;
  assign sel_dir_s   = b_win_s ? b_dir : a_dir;
  assign sel_steps_s = b_win_s ? b_steps : a_steps;

  // Next-state and next-output computation for the command FSM.
  always_comb begin
    state_d     = state_q;
    cnt_en_d    = 1'b0;
    cnt_dir_d   = cnt_dir_q;
    done_d      = 1'b0;
    grant_id_d  = grant_id_q;
    rr_b_last_d = rr_b_last_q;
    rem_d       = rem_q;
    settle_d    = settle_q;
    case (state_q)
      IDLE: begin
        if (a_win_s || b_win_s) begin
          grant_id_d  = b_win_s;
          rr_b_last_d = b_win_s;
          rem_d       = sel_steps_s;
          if (sel_steps_s == {STEP_W{1'b0}}) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (sel_dir_s != cnt_dir_q) begin
            // New direction is presented now so the counter's direction register settles before the first step.
            cnt_dir_d = sel_dir_s;
            settle_d  = SET_W'(SETTLE_CYC);
            state_d   = SETTLE;
          end else begin
            state_d  = RUN;
            cnt_en_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (settle_q <= SET_W'(1)) begin
          state_d  = RUN;
          cnt_en_d = 1'b1;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      RUN: begin
        if (rem_q <= STEP_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          rem_d    = rem_q - STEP_W'(1);
          cnt_en_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_en_q    <= 1'b0;
      cnt_dir_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      grant_id_q  <= 1'b0;
      rr_b_last_q <= 1'b1;
      rem_q       <= {STEP_W{1'b0}};
      settle_q    <= {SET_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_en_q    <= cnt_en_d;
      cnt_dir_q   <= cnt_dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      grant_id_q  <= grant_id_d;
      rr_b_last_q <= rr_b_last_d;
      rem_q       <= rem_d;
      settle_q    <= settle_d;
    end
  end

  assign cnt_en   = cnt_en_q;
  assign cnt_dir  = cnt_dir_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign grant_id = grant_id_q;

`ifdef SHADOW_POS_EN
  logic [CNT_W-1:0] shadow_q, shadow_d;

  // Shadow position follows each enabled step, wrapping modulo 2^CNT_W.
  always_comb begin
    shadow_d = shadow_q;
    if (cnt_en_q) begin
      if (cnt_dir_q) begin
        shadow_d = shadow_q - CNT_W'(1);
      end else begin
        shadow_d = shadow_q + CNT_W'(1);
      end
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Shadow position register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= {CNT_W{1'b0}};
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign shadow_pos = shadow_q;
`else
  assign shadow_pos = {CNT_W{1'b0}};
`endif

endmodule
